gty_reset_sequencer: RTL and testbench

Bring-up and recovery controller for one GTY transceiver channel. Sequences the wizard reset inputs after power-good, waits for TX then RX reset completion with per-phase timeouts and bounded retries, and supervises the running link, issuing an RX-datapath-only reset on CDR or RX loss. Sits between the GPIO control/status bus and the transceiver wizard, replacing software toggling of single-bit reset registers.

---
 rtl/gty_ctrl_pkg.sv | 25 ++
 rtl/gty_phase_timer.sv | 32 +++
 rtl/gty_reset_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_gty_reset_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gty_ctrl_pkg.sv
// Shared types and constants for the GTY channel reset sequencer.
package gty_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE       = 4'd0,
      ST_WAIT_PG    = 4'd1,
      ST_RST_ALL    = 4'd2,
      ST_WAIT_TX    = 4'd3,
      ST_WAIT_RX    = 4'd4,
      ST_LINK_UP    = 4'd5,
      ST_RX_RECOVER = 4'd6,
      ST_FAIL       = 4'd7
   } gty_state_t;

   // status word layout: {state[3:0], retry_cnt[3:0], recover_cnt[7:0]}
   localparam int STATUS_STATE_LSB   = 12;
   localparam int STATUS_RETRY_LSB   = 8;
   localparam int STATUS_RECOVER_LSB = 0;

   // Counter width for a cycle parameter, never narrower than one bit.
   function automatic int cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/gty_phase_timer.sv
// Down-counting phase timer. Loading restarts the phase at LOAD_VAL; the
// terminal count flags the last cycle of the phase.
module gty_phase_timer
   import gty_ctrl_pkg::*;
#(
   parameter int unsigned      WIDTH    = 4,
   parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_load,
   input  logic i_dec,
   output logic o_tc
);

   logic [WIDTH-1:0] r_count;
   logic             w_tc;

   assign w_tc = (r_count == '0);
   assign o_tc = w_tc;

   // Count down from the load value and park at zero.
   always_ff @(posedge clk) begin
      if (rst)
         r_count <= '0;
      else if (i_load)
         r_count <= LOAD_VAL;
      else if (i_dec && !w_tc)
         r_count <= r_count - 1'b1;
   end

endmodule

// File: rtl/gty_reset_sequencer.sv
// Bring-up and recovery sequencer for one GTY channel's reset wizard.
//
// state       | meaning
// ------------+------------------------------------------------------
// IDLE        | disabled, all outputs low
// WAIT_PG     | waiting for transceiver power good (timeout -> FAIL)
// RST_ALL     | full wizard reset pulse, PULSE_CYCLES wide
// WAIT_TX     | waiting for TX reset done (timeout -> retry)
// WAIT_RX     | waiting for RX reset done with CDR lock (timeout -> retry)
// LINK_UP     | link running, CDR/RX loss filtered
// RX_RECOVER  | RX datapath reset pulse after filtered link loss
// FAIL        | retries exhausted or no power good; held until enable drops
module gty_reset_sequencer
   import gty_ctrl_pkg::*;
#(
   parameter int unsigned PULSE_CYCLES   = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned LOSS_FILTER    = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        gtpowergood_out,
   input  logic        gtwiz_reset_tx_done_out,
   input  logic        gtwiz_reset_rx_done_out,
   input  logic        gtwiz_reset_rx_cdr_stable_out,
   output logic        gtwiz_reset_all_in,
   output logic        gtwiz_reset_rx_datapath_in,
   output logic        gtwiz_userclk_tx_active_in,
   output logic        gtwiz_userclk_rx_active_in,
   output logic        link_up,
   output logic        fail,
   output logic [15:0] status
);

   localparam int unsigned PW = cnt_width(PULSE_CYCLES);
   localparam int unsigned TW = cnt_width(TIMEOUT_CYCLES);
   localparam int unsigned LW = cnt_width(LOSS_FILTER);

   // Down-counters start at N-1 so terminal count lands on the N-th cycle.
   localparam logic [PW-1:0] PULSE_LOAD   = PW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [LW-1:0] LOSS_LOAD    = LW'(LOSS_FILTER - 1);
   localparam logic [3:0]    MAX_RETRY_L  = 4'(MAX_RETRIES);

   gty_state_t r_state;
   gty_state_t w_next_state;
   logic [3:0] r_retry_cnt;
   logic [7:0] r_recover_cnt;

   logic w_state_chg;
   logic w_retry;
   logic w_pg_abort;
   logic w_link_bad;
   logic w_pulse_tc;
   logic w_timeout_tc;
   logic w_loss_tc;

   logic w_reset_all;
   logic w_rx_datapath;
   logic w_tx_active;
   logic w_rx_active;
   logic w_link_up;
   logic w_fail;

   logic r_reset_all;
   logic r_rx_datapath;
   logic r_tx_active;
   logic r_rx_active;
   logic r_link_up;
   logic r_fail;

   assign w_state_chg = (w_next_state != r_state);
   assign w_link_bad  = !gtwiz_reset_rx_done_out || !gtwiz_reset_rx_cdr_stable_out;
   assign w_pg_abort  = !gtpowergood_out &&
                        (r_state != ST_IDLE) && (r_state != ST_WAIT_PG) && (r_state != ST_FAIL);

   gty_phase_timer #(.WIDTH(PW), .LOAD_VAL(PULSE_LOAD)) u_pulse_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_state_chg),
      .i_dec  (1'b1),
      .o_tc   (w_pulse_tc)
   );

   gty_phase_timer #(.WIDTH(TW), .LOAD_VAL(TIMEOUT_LOAD)) u_timeout_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_state_chg),
      .i_dec  (1'b1),
      .o_tc   (w_timeout_tc)
   );

   // A single good cycle restarts the loss filter.
   gty_phase_timer #(.WIDTH(LW), .LOAD_VAL(LOSS_LOAD)) u_loss_timer (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_state_chg || !w_link_bad),
      .i_dec  (r_state == ST_LINK_UP),
      .o_tc   (w_loss_tc)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         r_state <= ST_IDLE;
      else
         r_state <= w_next_state;
   end

   // Next-state logic; enable and power-good loss override every phase.
   always_comb begin
      w_next_state = r_state;
      w_retry      = 1'b0;
      if (!enable) begin
         w_next_state = ST_IDLE;
      end else if (w_pg_abort) begin
         w_next_state = ST_WAIT_PG;
      end else begin
         case (r_state)
            ST_IDLE:
               w_next_state = ST_WAIT_PG;
            ST_WAIT_PG:
               if (gtpowergood_out)
                  w_next_state = ST_RST_ALL;
               else if (w_timeout_tc)
                  w_next_state = ST_FAIL;
            ST_RST_ALL:
               if (w_pulse_tc)
                  w_next_state = ST_WAIT_TX;
            ST_WAIT_TX:
               if (gtwiz_reset_tx_done_out)
                  w_next_state = ST_WAIT_RX;
               else if (w_timeout_tc)
                  w_retry = 1'b1;
            ST_WAIT_RX:
               if (!w_link_bad)
                  w_next_state = ST_LINK_UP;
               else if (w_timeout_tc)
                  w_retry = 1'b1;
            ST_LINK_UP:
               if (w_link_bad && w_loss_tc)
                  w_next_state = ST_RX_RECOVER;
            ST_RX_RECOVER:
               if (w_pulse_tc)
                  w_next_state = ST_WAIT_RX;
            ST_FAIL:
               w_next_state = ST_FAIL;
            default:
               w_next_state = ST_IDLE;
         endcase
         if (w_retry)
            w_next_state = (r_retry_cnt < MAX_RETRY_L) ? ST_RST_ALL : ST_FAIL;
      end
   end

   // Output decode from the state being entered so outputs register with it.
   always_comb begin
      w_reset_all   = (w_next_state == ST_RST_ALL);
      w_rx_datapath = (w_next_state == ST_RX_RECOVER);
      w_tx_active   = (w_next_state == ST_WAIT_TX) || (w_next_state == ST_WAIT_RX) ||
                      (w_next_state == ST_LINK_UP) || (w_next_state == ST_RX_RECOVER);
      w_rx_active   = (w_next_state == ST_WAIT_RX) || (w_next_state == ST_LINK_UP) ||
                      (w_next_state == ST_RX_RECOVER);
      w_link_up     = (w_next_state == ST_LINK_UP);
      w_fail        = (w_next_state == ST_FAIL);
   end

   // Registered wizard controls and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_reset_all   <= 1'b0;
         r_rx_datapath <= 1'b0;
         r_tx_active   <= 1'b0;
         r_rx_active   <= 1'b0;
         r_link_up     <= 1'b0;
         r_fail        <= 1'b0;
      end else begin
         r_reset_all   <= w_reset_all;
         r_rx_datapath <= w_rx_datapath;
         r_tx_active   <= w_tx_active;
         r_rx_active   <= w_rx_active;
         r_link_up     <= w_link_up;
         r_fail        <= w_fail;
      end
   end

   // Retry count restarts on a fresh bring-up, on PG loss and once the link is up.
   always_ff @(posedge clk) begin
      if (rst)
         r_retry_cnt <= '0;
      else if (w_state_chg && ((w_next_state == ST_IDLE) || (w_next_state == ST_WAIT_PG) ||
                               (w_next_state == ST_LINK_UP)))
         r_retry_cnt <= '0;
      else if (w_retry && (w_next_state == ST_RST_ALL))
         r_retry_cnt <= r_retry_cnt + 1'b1;
   end

   // Lifetime count of RX recoveries; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst)
         r_recover_cnt <= '0;
      else if (w_state_chg && (w_next_state == ST_RX_RECOVER) && (r_recover_cnt != 8'hFF))
         r_recover_cnt <= r_recover_cnt + 1'b1;
   end

   // Status word assembled from registered fields.
   always_comb begin
      status = '0;
      status[STATUS_STATE_LSB   +: 4] = r_state;
      status[STATUS_RETRY_LSB   +: 4] = r_retry_cnt;
      status[STATUS_RECOVER_LSB +: 8] = r_recover_cnt;
   end

   assign gtwiz_reset_all_in         = r_reset_all;
   assign gtwiz_reset_rx_datapath_in = r_rx_datapath;
   assign gtwiz_userclk_tx_active_in = r_tx_active;
   assign gtwiz_userclk_rx_active_in = r_rx_active;
   assign link_up                    = r_link_up;
   assign fail                       = r_fail;

endmodule

// File: tb/tb_gty_reset_sequencer.sv
// Directed bench for gty_reset_sequencer with a 1000-cycle phase timeout.
module tb_gty_reset_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        pg;
   logic        tx_done;
   logic        rx_done;
   logic        cdr;
   logic        reset_all;
   logic        rx_dp;
   logic        tx_act;
   logic        rx_act;
   logic        link_up;
   logic        fail;
   logic [15:0] status;

   gty_reset_sequencer #(
      .PULSE_CYCLES   (16),
      .TIMEOUT_CYCLES (1000),
      .MAX_RETRIES    (3),
      .LOSS_FILTER    (64)
   ) dut (
      .clk                           (clk),
      .rst                           (rst),
      .enable                        (enable),
      .gtpowergood_out               (pg),
      .gtwiz_reset_tx_done_out       (tx_done),
      .gtwiz_reset_rx_done_out       (rx_done),
      .gtwiz_reset_rx_cdr_stable_out (cdr),
      .gtwiz_reset_all_in            (reset_all),
      .gtwiz_reset_rx_datapath_in    (rx_dp),
      .gtwiz_userclk_tx_active_in    (tx_act),
      .gtwiz_userclk_rx_active_in    (rx_act),
      .link_up                       (link_up),
      .fail                          (fail),
      .status                        (status)
   );

   always #5 clk = ~clk;

   // output bits {reset_all, rx_datapath, tx_active, rx_active, link_up, fail}
   localparam logic [5:0] O_OFF = 6'b000000;
   localparam logic [5:0] O_RA  = 6'b100000;
   localparam logic [5:0] O_TX  = 6'b001000;
   localparam logic [5:0] O_RX  = 6'b001100;
   localparam logic [5:0] O_LU  = 6'b001110;
   localparam logic [5:0] O_RR  = 6'b011100;
   localparam logic [5:0] O_FL  = 6'b000001;

   // input bits {enable, powergood, tx_done, rx_done, cdr_stable}
   typedef struct {
      logic [4:0]  in;
      int          n;
      logic [5:0]  exp_o;
      logic [15:0] exp_st;
   } vec_t;

   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic add(input logic [4:0] in, input int n, input logic [5:0] o, input logic [15:0] st);
      vec_t v;
      v.in = in; v.n = n; v.exp_o = o; v.exp_st = st;
      tbl.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] in);
      {enable, pg, tx_done, rx_done, cdr} = in;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [5:0] outs();
      return {reset_all, rx_dp, tx_act, rx_act, link_up, fail};
   endfunction

   initial begin
      int pulses, high, run, bad_run, fail_cyc;
      logic prev, got;

      // abort mid RST_ALL pulse
      add(5'b11000,    1, O_OFF, 16'h1000);
      add(5'b11000,    1, O_RA,  16'h2000);
      add(5'b11000,    5, O_RA,  16'h2000);
      add(5'b01000,    1, O_OFF, 16'h0000);
      // nominal bring-up, PG arrives on cycle 5
      add(5'b10000,    1, O_OFF, 16'h1000);
      add(5'b10000,    4, O_OFF, 16'h1000);
      add(5'b11000,    1, O_RA,  16'h2000);
      add(5'b11000,   15, O_RA,  16'h2000);
      add(5'b11000,    1, O_TX,  16'h3000);
      add(5'b11000,   99, O_TX,  16'h3000);
      add(5'b11100,    1, O_RX,  16'h4000);
      add(5'b11100,  199, O_RX,  16'h4000);
      add(5'b11111,    1, O_LU,  16'h5000);
      add(5'b11111,   10, O_LU,  16'h5000);
      // CDR glitch 63 cycles, then 64 cycles
      add(5'b11110,   63, O_LU,  16'h5000);
      add(5'b11111,    1, O_LU,  16'h5000);
      add(5'b11110,   63, O_LU,  16'h5000);
      add(5'b11110,    1, O_RR,  16'h6001);
      add(5'b11110,   15, O_RR,  16'h6001);
      add(5'b11110,    1, O_RX,  16'h4001);
      add(5'b11111,    1, O_LU,  16'h5001);
      // RX done loss for 64 cycles
      add(5'b11101,   64, O_RR,  16'h6002);
      add(5'b11111,   16, O_RX,  16'h4002);
      add(5'b11111,    1, O_LU,  16'h5002);
      // loss filter hit coincides with PG loss: PG wins
      add(5'b11110,   63, O_LU,  16'h5002);
      add(5'b10110,    1, O_OFF, 16'h1002);
      // PG returns: full sequence reruns
      add(5'b11111,    1, O_RA,  16'h2002);
      add(5'b11111,   15, O_RA,  16'h2002);
      add(5'b11111,    1, O_TX,  16'h3002);
      add(5'b11111,    1, O_RX,  16'h4002);
      add(5'b11111,    1, O_LU,  16'h5002);
      add(5'b01111,    1, O_OFF, 16'h0002);
      // WAIT_PG timeout -> FAIL without retry, sticky
      add(5'b10000,    1, O_OFF, 16'h1002);
      add(5'b10000,  999, O_OFF, 16'h1002);
      add(5'b10000,    1, O_FL,  16'h7002);
      add(5'b10000,   20, O_FL,  16'h7002);
      add(5'b11000,    5, O_FL,  16'h7002);
      add(5'b01000,    1, O_OFF, 16'h0002);
      // WAIT_RX exit on the timeout cycle wins
      add(5'b11100,    1, O_OFF, 16'h1002);
      add(5'b11100,    1, O_RA,  16'h2002);
      add(5'b11100,   16, O_TX,  16'h3002);
      add(5'b11100,    1, O_RX,  16'h4002);
      add(5'b11100,  999, O_RX,  16'h4002);
      add(5'b11111,    1, O_LU,  16'h5002);
      // WAIT_RX timeout with rx_done but no CDR -> retry
      add(5'b10000,    1, O_OFF, 16'h1002);
      add(5'b11110,    1, O_RA,  16'h2002);
      add(5'b11110,   16, O_TX,  16'h3002);
      add(5'b11110,    1, O_RX,  16'h4002);
      add(5'b11110, 1000, O_RA,  16'h2102);
      add(5'b01110,    1, O_OFF, 16'h0002);

      rst = 1'b1;
      drive(5'b00000);
      tick();
      tick();
      rst = 1'b0;
      chk("reset outputs", 32'(outs()), 32'(O_OFF));
      chk("reset status", 32'(status), 32'h0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].in);
         repeat (tbl[i].n) tick();
         chk($sformatf("vec%0d outputs", i), 32'(outs()), 32'(tbl[i].exp_o));
         chk($sformatf("vec%0d status", i), 32'(status), 32'(tbl[i].exp_st));
      end

      // TX never completes: four reset_all pulses then FAIL
      drive(5'b11000);
      pulses = 0; high = 0; run = 0; bad_run = 0; fail_cyc = 0;
      prev = 1'b0; got = 1'b0;
      for (int c = 1; c <= 5000 && !got; c++) begin
         tick();
         if (reset_all) begin
            high++;
            run++;
            if (!prev) pulses++;
         end else begin
            if (prev && run != 16) bad_run++;
            run = 0;
         end
         prev = reset_all;
         if (fail) begin
            got = 1'b1;
            fail_cyc = c;
         end
      end
      chk("tx timeout reached fail", 32'(got), 32'h1);
      chk("tx timeout pulse count", 32'(pulses), 32'd4);
      chk("tx timeout pulse high cycles", 32'(high), 32'd64);
      chk("tx timeout bad pulse widths", 32'(bad_run), 32'd0);
      chk("tx timeout fail cycle", 32'(fail_cyc), 32'd4066);
      chk("tx timeout status", 32'(status), 32'h7302);
      drive(5'b01000);
      tick();
      chk("fail release outputs", 32'(outs()), 32'(O_OFF));
      chk("fail release status", 32'(status), 32'h0002);

      // rst mid-pulse clears everything including recover count
      drive(5'b11000);
      tick();
      tick();
      chk("pre-rst pulse", 32'(outs()), 32'(O_RA));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst outputs", 32'(outs()), 32'(O_OFF));
      chk("rst status", 32'(status), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
